// File: rtl/iob_split_pipe_pkg.sv
// Shared constants and width helpers for the pipelined IOb split.
package iob_split_pipe_pkg;

    localparam logic [31:0] ERR_DATA_DEF = 32'hDEADBEEF;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) if ((1 << r) < v) r++;
        return (r == 0) ? 1 : r;
    endfunction

    function automatic int req_pack_w(input int aw, input int dw);
        return 1 + aw + dw + dw / 8;
    endfunction

    function automatic int rsp_pack_w(input int dw);
        return dw + 1;
    endfunction

    localparam int REQ_PACK_W = req_pack_w(32, 32);
    localparam int RSP_PACK_W = rsp_pack_w(32);

endpackage

// File: rtl/iob_split_pipe_err.sv
// Error responder: answers an unmapped accept with one ERR_DATA/rerr pulse next cycle.
module iob_split_pipe_err
    import iob_split_pipe_pkg::*;
#(
    parameter int                DATA_W   = 32,
    parameter logic [DATA_W-1:0] ERR_DATA = DATA_W'(ERR_DATA_DEF)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          set,
    output logic                          vld,
    output logic [rsp_pack_w(DATA_W)-1:0] rsp
);

    logic err_pend_q, err_pend_d;

    always_comb begin
        err_pend_d = set;
        vld        = err_pend_q;
        rsp        = err_pend_q ? {1'b1, ERR_DATA} : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) err_pend_q <= 1'b0;
        else     err_pend_q <= err_pend_d;
    end

endmodule

// File: rtl/iob_split_pipe.sv
// Pipelined in-order IOb 1:N split with unmapped-select error responses.
// Optional IOB_SPLIT_PIPE_TIMEOUT_EN adds a hung-slave timeout and drop logic.
module iob_split_pipe
    import iob_split_pipe_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter int                N_SLAVES = 3,
    parameter int                SEL_W    = 2,
    parameter int                P_SLAVES = 31,
    parameter int                MAX_OUT  = 4,
    parameter logic [DATA_W-1:0] ERR_DATA = DATA_W'(ERR_DATA_DEF)
`ifdef IOB_SPLIT_PIPE_TIMEOUT_EN
   ,parameter int                TIMEOUT_CYC = 1023
`endif
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           m_valid,
    input  logic [ADDR_W-1:0]              m_addr,
    input  logic [DATA_W-1:0]              m_wdata,
    input  logic [DATA_W/8-1:0]            m_wstrb,
    output logic                           m_ready,
    output logic                           m_rvalid,
    output logic [DATA_W-1:0]              m_rdata,
    output logic                           m_rerr,
    output logic [N_SLAVES-1:0]            s_valid,
    output logic [N_SLAVES*ADDR_W-1:0]     s_addr,
    output logic [N_SLAVES*DATA_W-1:0]     s_wdata,
    output logic [N_SLAVES*DATA_W/8-1:0]   s_wstrb,
    input  logic [N_SLAVES-1:0]            s_ready,
    input  logic [N_SLAVES-1:0]            s_rvalid,
    input  logic [N_SLAVES*DATA_W-1:0]     s_rdata,
    output logic                           stray
`ifdef IOB_SPLIT_PIPE_TIMEOUT_EN
   ,output logic                           timeout
`endif
);

    localparam int CNT_W = clog2(MAX_OUT + 1);
    localparam int RSP_W = rsp_pack_w(DATA_W);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SEL_W-1:0] cur_sel_q, cur_sel_d;
    logic             stray_q, stray_d;

    logic [SEL_W-1:0] sel;
    logic             mapped, idle, ok, sel_rdy, live, slv_rv, rsp_slave;
    logic [DATA_W-1:0] slv_rd;
    logic             err_vld;
    logic [RSP_W-1:0] err_rsp;

`ifdef IOB_SPLIT_PIPE_TIMEOUT_EN
    localparam int WAIT_W = clog2(TIMEOUT_CYC + 1);
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [CNT_W-1:0]  drop_q, drop_d;
    logic              timeout_q, timeout_d;
    logic              to_fire, consume;
`endif

    assign s_addr  = {N_SLAVES{m_addr}};
    assign s_wdata = {N_SLAVES{m_wdata}};
    assign s_wstrb = {N_SLAVES{m_wstrb}};
    assign stray   = stray_q;

    always_comb begin
        sel    = m_addr[P_SLAVES -: SEL_W];
        mapped = 32'(sel) < N_SLAVES;
`ifdef IOB_SPLIT_PIPE_TIMEOUT_EN
        // A late answer to a timed-out request must still be routed, so the
        // drop backlog keeps the current target locked like an outstanding one.
        idle = (cnt_q == '0) && (drop_q == '0);
        live = (cnt_q != '0) || (drop_q != '0);
`else
        idle = (cnt_q == '0);
        live = (cnt_q != '0);
`endif
        ok = (cnt_q < CNT_W'(MAX_OUT)) && (idle || (sel == cur_sel_q));

        s_valid = '0;
        sel_rdy = 1'b0;
        slv_rv  = 1'b0;
        slv_rd  = '0;
        stray_d = stray_q;
        for (int i = 0; i < N_SLAVES; i++) begin
            if (SEL_W'(i) == sel) begin
                s_valid[i] = m_valid && ok && mapped;
                sel_rdy    = s_ready[i];
            end
            if (live && SEL_W'(i) == cur_sel_q) begin
                slv_rv = s_rvalid[i];
                slv_rd = s_rdata[i*DATA_W +: DATA_W];
            end else if (s_rvalid[i]) begin
                stray_d = 1'b1;
            end
        end

        m_ready   = m_valid && ok && (mapped ? sel_rdy : 1'b1);
        cur_sel_d = m_ready ? sel : cur_sel_q;

`ifdef IOB_SPLIT_PIPE_TIMEOUT_EN
        consume   = slv_rv && (drop_q != '0);
        rsp_slave = slv_rv && (drop_q == '0);
        to_fire   = (wait_q == WAIT_W'(TIMEOUT_CYC)) && (cnt_q != '0) && !err_vld && !rsp_slave;
        m_rvalid  = err_vld || rsp_slave || to_fire;
        m_rerr    = err_vld || to_fire;
        m_rdata   = err_vld ? err_rsp[DATA_W-1:0] : to_fire ? ERR_DATA : rsp_slave ? slv_rd : '0;
        wait_d    = (m_rvalid || cnt_q == '0) ? '0 :
                    (wait_q == WAIT_W'(TIMEOUT_CYC)) ? wait_q : wait_q + 1'b1;
        drop_d    = drop_q + CNT_W'(to_fire) - CNT_W'(consume);
        timeout_d = timeout_q || to_fire;
        timeout   = timeout_q;
`else
        rsp_slave = slv_rv;
        m_rvalid  = err_vld || rsp_slave;
        m_rerr    = err_vld;
        m_rdata   = err_vld ? err_rsp[DATA_W-1:0] : rsp_slave ? slv_rd : '0;
`endif

        case ({m_ready, m_rvalid})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    iob_split_pipe_err #(
        .DATA_W   (DATA_W),
        .ERR_DATA (ERR_DATA)
    ) u_err (
        .clk (clk),
        .rst (rst),
        .set (m_ready && !mapped),
        .vld (err_vld),
        .rsp (err_rsp)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            cur_sel_q <= '0;
            stray_q   <= 1'b0;
`ifdef IOB_SPLIT_PIPE_TIMEOUT_EN
            wait_q    <= '0;
            drop_q    <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            cnt_q     <= cnt_d;
            cur_sel_q <= cur_sel_d;
            stray_q   <= stray_d;
`ifdef IOB_SPLIT_PIPE_TIMEOUT_EN
            wait_q    <= wait_d;
            drop_q    <= drop_d;
            timeout_q <= timeout_d;
`endif
        end
    end

endmodule
